// File: rtl/sdram_burst_responder.sv
// Responder for the cache's SDRAM line-fill interface: accepts one request and streams
// a full line back critical word first, driving an in-order pipelined word-wide backend.
module sdram_burst_responder #(
    parameter int ADDR_WIDTH      = 26,
    parameter int LINE_WORDS      = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sdram_request,
    output logic                  sdram_ready,
    input  logic [ADDR_WIDTH-1:0] sdram_address,
    output logic                  sdram_rvalid,
    output logic [ADDR_WIDTH-1:0] sdram_raddress,
    output logic [DATA_W-1:0]     sdram_rdata,
    output logic                  sdram_complete,
    output logic                  mem_request,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int BASE_W = ADDR_WIDTH - IDX_W - 2;
    localparam int CNT_W  = IDX_W + 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);
    localparam logic [OUT_W-1:0] OUT_CAP  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_next;
    logic [BASE_W-1:0] base;
    logic [IDX_W-1:0]  start;
    logic [CNT_W-1:0]  issue_cnt, ret_cnt;
    logic [OUT_W-1:0]  outstanding;
    logic              accept, issue_fire, ret_fire, ret_last;
    logic [IDX_W-1:0]  issue_idx, ret_idx;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^sdram_address[1:0];

    assign accept     = sdram_request && sdram_ready;
    assign issue_fire = mem_request && mem_ready;
    // Once the whole line has returned, stray backend beats are dropped.
    assign ret_fire   = mem_rvalid && (state != IDLE) && (ret_cnt != LINE_CNT);
    assign ret_last   = ret_fire && (ret_cnt == LAST_CNT);
    assign issue_idx  = start + issue_cnt[IDX_W-1:0];
    assign ret_idx    = start + ret_cnt[IDX_W-1:0];
    assign mem_address = {base, issue_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Leave for IDLE only after sdram_complete has been shown, so ready reappears a cycle later.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE: begin
                if (sdram_complete)             state_next = IDLE;
                else if (issue_cnt == LINE_CNT) state_next = DRAIN;
            end
            DRAIN:   if (sdram_complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sdram_ready = (state == IDLE) && !reset;
        mem_request = (state == ISSUE) && (issue_cnt < LINE_CNT) && (outstanding < OUT_CAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base        <= '0;
            start       <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
        end else if (accept) begin
            base        <= sdram_address[ADDR_WIDTH-1:IDX_W+2];
            start       <= sdram_address[IDX_W+1:2];
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
        end else begin
            if (issue_fire) issue_cnt <= issue_cnt + 1'b1;
            if (ret_fire)   ret_cnt   <= ret_cnt + 1'b1;
            outstanding <= outstanding + OUT_W'(issue_fire) - OUT_W'(ret_fire);
        end
    end

    // Return stage: one-cycle register from the backend beat to the cache.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdram_rvalid   <= 1'b0;
            sdram_complete <= 1'b0;
            sdram_rdata    <= '0;
            sdram_raddress <= '0;
        end else begin
            sdram_rvalid   <= ret_fire;
            sdram_complete <= ret_last;
            if (ret_fire) begin
                sdram_rdata    <= mem_rdata;
                sdram_raddress <= {base, ret_idx, 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Scoreboard bench for sdram_burst_responder: a fixed-latency in-order backend model,
// directed line fills, and a monitor that pops expected beats as the DUT returns them.
module tb_sdram_burst_responder;

    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int LW   = 16;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sdram_request = 1'b0;
    logic          sdram_ready;
    logic [AW-1:0] sdram_address = '0;
    logic          sdram_rvalid;
    logic [AW-1:0] sdram_raddress;
    logic [DW-1:0] sdram_rdata;
    logic          sdram_complete;
    logic          mem_request;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    sdram_burst_responder #(
        .ADDR_WIDTH(AW), .LINE_WORDS(LW), .MAX_OUTSTANDING(MAXO), .DATA_W(DW)
    ) dut (
        .clk(clk), .reset(reset),
        .sdram_request(sdram_request), .sdram_ready(sdram_ready), .sdram_address(sdram_address),
        .sdram_rvalid(sdram_rvalid), .sdram_raddress(sdram_raddress), .sdram_rdata(sdram_rdata),
        .sdram_complete(sdram_complete),
        .mem_request(mem_request), .mem_ready(mem_ready), .mem_address(mem_address),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {6'h2B, a};
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          c;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        longint        due;
    } pend_t;

    exp_t   exp_q[$];
    pend_t  pend_q[$];

    // Backend model state
    int     lat = 3;
    int     ready_mode = 0;
    longint cyc = 0;
    int     inflight = 0;
    int     peak = 0;
    logic   prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) begin
        pend_t p;
        cyc++;
        if (prev_stall && !reset) begin
            chk("hold_mem_request", mem_request, 1);
            chk("hold_mem_address", mem_address, prev_addr);
        end
        prev_stall = mem_request && !mem_ready && !reset;
        prev_addr  = mem_address;
        if (mem_rvalid) inflight--;
        if (mem_request && mem_ready && !reset) begin
            p.a = mem_address;
            p.due = cyc + lat;
            pend_q.push_back(p);
            inflight++;
        end
        if (inflight > peak) peak = inflight;
    end

    always @(negedge clk) begin
        if (ready_mode == 0) mem_ready = 1'b1;
        else                 mem_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mdata(pend_q[0].a);
            void'(pend_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    end

    // Monitor
    int   beats = 0;
    int   completes = 0;
    bit   busy = 1'b0;
    bit   exp_ready_next = 1'b0;
    exp_t e;

    always @(posedge clk) begin
        #1;
        if (exp_ready_next) begin
            chk("ready_after_complete", sdram_ready, 1);
            exp_ready_next = 1'b0;
        end else if (busy) begin
            chk("ready_low_while_busy", sdram_ready, 0);
        end
        if (sdram_complete) chk("complete_has_rvalid", sdram_rvalid, 1);
        if (sdram_rvalid) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_rvalid: raddress %0h data %0h, required no beat", sdram_raddress, sdram_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("raddress", sdram_raddress, e.a);
                chk("rdata", sdram_rdata, e.d);
                chk("complete_flag", sdram_complete, e.c);
            end
        end
        if (sdram_complete) begin
            completes++;
            busy = 1'b0;
            exp_ready_next = 1'b1;
        end
    end

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!sdram_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", sdram_ready, 1);
    endtask

    task automatic issue_req(input logic [AW-1:0] a, input int hold, output int waited);
        exp_t x;
        logic [3:0] idx;
        wait_ready(waited);
        sdram_request = 1'b1;
        sdram_address = a;
        busy = 1'b1;
        for (int i = 0; i < LW; i++) begin
            idx = a[5:2] + 4'(i);
            x.a = {a[AW-1:6], idx, 2'b00};
            x.d = mdata(x.a);
            x.c = (i == LW - 1);
            exp_q.push_back(x);
        end
        repeat (hold) @(negedge clk);
        sdram_request = 1'b0;
    endtask

    task automatic wait_bursts(input int n);
        int t;
        t = 0;
        while (completes < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("burst_done", (completes >= n), 1);
    endtask

    task automatic run_fill(input logic [AW-1:0] a);
        int w;
        beats = 0;
        completes = 0;
        peak = 0;
        issue_req(a, 1, w);
        wait_bursts(1);
        chk("beat_count", beats, 16);
        chk("complete_count", completes, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int w;
        int t;
        repeat (3) @(negedge clk);
        chk("rst_ready", sdram_ready, 0);
        chk("rst_rvalid", sdram_rvalid, 0);
        chk("rst_complete", sdram_complete, 0);
        chk("rst_mem_request", mem_request, 0);
        chk("rst_rdata", sdram_rdata, 0);
        chk("rst_raddress", sdram_raddress, 0);
        chk("rst_mem_address", mem_address, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", sdram_ready, 1);

        // Line-aligned fill, latency 3
        lat = 3;
        ready_mode = 0;
        run_fill(26'h0001040);
        chk("peak_lat3", peak, 3);

        // Critical word first (word 13), and start = 15 wrap
        run_fill(26'h0001074);
        run_fill(26'h000107C);

        // Outstanding cap with long latency
        lat = 10;
        run_fill(26'h0001040);
        chk("peak_cap", peak, 4);

        // Backend backpressure
        lat = 3;
        ready_mode = 1;
        run_fill(26'h0001088);
        ready_mode = 0;

        // Request held 3 cycles, then back-to-back request
        beats = 0;
        completes = 0;
        issue_req(26'h00010C0, 3, w);
        wait_bursts(1);
        chk("held_beats", beats, 16);
        chk("held_completes", completes, 1);
        issue_req(26'h0001100, 1, w);
        chk("b2b_wait_cycles", w, 1);
        chk("b2b_accepted", sdram_ready, 0);
        wait_bursts(2);
        chk("b2b_beats", beats, 32);
        chk("b2b_completes", completes, 2);

        // Reset mid-burst with reads in flight
        beats = 0;
        completes = 0;
        issue_req(26'h0001000, 1, w);
        t = 0;
        while (beats < 5 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("beats_before_reset", beats, 5);
        chk("inflight_at_reset", inflight, 3);
        reset = 1'b1;
        exp_q.delete();
        busy = 1'b0;
        exp_ready_next = 1'b0;
        beats = 0;
        @(posedge clk);
        #1;
        chk("midrst_rvalid", sdram_rvalid, 0);
        chk("midrst_mem_request", mem_request, 0);
        chk("midrst_complete", sdram_complete, 0);
        chk("midrst_ready", sdram_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", sdram_ready, 1);
        t = 0;
        while (inflight != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("late_returns_ignored", beats, 0);
        run_fill(26'h0002000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_burst_responder.md
Name: sdram_burst_responder

Overview:
- Responder end of the SDRAM burst-read interface that the read cache initiates on.
- Accepts one line-fill request (address plus request/ready handshake) and streams back a full 16-word line, critical word first.
- Returns each word with its address, and flags the last word with `sdram_complete`.
- Backend side is a pipelined, in-order, word-wide memory port (the SDRAM controller core), with bounded outstanding reads.

Parameters:
- ADDR_WIDTH, 26, byte-address width; bits [1:0] ignored.
- LINE_WORDS, 16, words per burst; power of two; word index is address bits [5:2].
- MAX_OUTSTANDING, 4, maximum backend reads issued but not yet returned (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sdram_request  in  1  line-fill request from the cache
- sdram_ready  out  1  responder can accept a request this cycle
- sdram_address  in  26  requested byte address; selects line and critical word
- sdram_rvalid  out  1  returned word valid
- sdram_raddress  out  26  byte address of the returned word; bits [1:0] = 0
- sdram_rdata  out  32  returned word
- sdram_complete  out  1  asserted with `sdram_rvalid` on the last word of the burst
- mem_request  out  1  backend word read request
- mem_ready  in  1  backend accepts `mem_request` this cycle
- mem_address  out  26  backend word address; bits [1:0] = 0
- mem_rvalid  in  1  backend read data valid; data returns in issue order
- mem_rdata  in  32  backend read data

Behaviour:
- One clock `clk`. Reset is synchronous, active-high, named `reset`.
- Reset values:
  - `sdram_ready` = 0 during reset.
  - `sdram_rvalid` = 0, `sdram_complete` = 0, `mem_request` = 0.
  - `sdram_rdata` = 0, `sdram_raddress` = 0, `mem_address` = 0.
  - State = IDLE; all counters = 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - `sdram_ready` = 1 (combinational from state, and !reset).
  - Acceptance occurs on a cycle where `sdram_request` && `sdram_ready`.
  - On acceptance: latch base = address[25:6] and start = address[5:2]; clear issue_cnt, ret_cnt, outstanding; go to ISSUE.
  - `sdram_ready` is 0 in every non-IDLE state, so a request the cache holds for one cycle after acceptance is not taken twice.
- ISSUE:
  - `mem_request` = 1 while issue_cnt < LINE_WORDS and outstanding < MAX_OUTSTANDING.
  - `mem_address` = {base, (start + issue_cnt) mod LINE_WORDS, 2'b00}, a 4-bit wrap inside the line.
  - On `mem_request` && `mem_ready`: issue_cnt increments.
  - `mem_request`/`mem_address` are held stable until accepted.
  - When issue_cnt reaches LINE_WORDS, go to DRAIN.
- Outstanding counter:
  - +1 on backend acceptance, -1 on `mem_rvalid`; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING; `mem_request` deasserts at the cap.
- Return path (active in ISSUE and DRAIN), on `mem_rvalid`, next cycle:
  - `sdram_rvalid` = 1 and `sdram_rdata` = `mem_rdata`.
  - `sdram_raddress` = {base, (start + ret_cnt) mod LINE_WORDS, 2'b00}.
  - ret_cnt increments.
  - `sdram_complete` = 1 when ret_cnt was LINE_WORDS-1, then go to IDLE.
  - There is no backpressure toward the cache; every backend word is forwarded exactly once.
- Latency:
  - Acceptance at cycle T gives the first `mem_request` at T+1.
  - The cache sees each word 1 cycle after `mem_rvalid`.
  - `sdram_ready` returns to 1 in the cycle after `sdram_complete`.
- Back-to-back: a new request may be accepted in the cycle `sdram_ready` reappears; no dead cycle beyond that.
- Boundaries:
  - start = 15 gives word order 15, 0, 1, …, 14; the burst never crosses the line.
  - `mem_rvalid` in IDLE is ignored: no `sdram_rvalid`.
  - `sdram_request` in a non-IDLE state is ignored.
  - Reset mid-burst aborts immediately: outputs take reset values next cycle, and late backend returns are ignored. The backend is reset by the same `reset`.
- `sdram_complete` is never asserted without `sdram_rvalid`.

Test Plan:
- Line-aligned fill: request 0x0001040, mem latency 3, mem_ready=1 → 16 `sdram_rvalid` beats with raddress 0x0001040, 0x0001044, …, 0x000107C. `sdram_complete` only on 0x000107C. `sdram_ready` = 0 from the acceptance cycle until the cycle after complete.
- Critical word first: request 0x0001074 (word 13) → raddress order 0x0001074, 0x0001078, 0x000107C, 0x0001040, …, 0x0001070. Complete on 0x0001070. Data matches the memory model.
- Outstanding cap: mem latency 10, MAX_OUTSTANDING=4 → never more than 4 unreturned issues. `mem_request` drops after 4 issues and resumes one cycle after each return. All 16 words arrive in order.
- Backend backpressure: mem_ready toggling 1,0,0,1 → `mem_address` is stable while not accepted, with no skipped or duplicated words. Exactly 16 returns, 1 complete.
- Cache request held: `sdram_request` high for 3 cycles from acceptance → exactly one burst (16 beats, 1 complete). A second request raised the cycle `sdram_ready` returns is accepted immediately.
- Reset mid-burst: reset asserted after 5 returned words, with 3 backend reads in flight → next cycle `sdram_rvalid`=0, `mem_request`=0; `sdram_ready`=1 once reset drops. The late `mem_rvalid` beats produce no output. A new request 0x0002000 completes normally.
